// File: rtl/salsa20_pkg.sv
// salsa20_pkg: Salsa20 rotate/sigma constants, round word-index tables and rotl32.
package salsa20_pkg;
   localparam int unsigned ROT_B = 7;
   localparam int unsigned ROT_C = 9;
   localparam int unsigned ROT_D = 13;
   localparam int unsigned ROT_A = 18;
   localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
   localparam int COL_IDX [4][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11}};
   localparam int ROW_IDX [4][4] = '{'{0, 1, 2, 3}, '{5, 6, 7, 4}, '{10, 11, 8, 9}, '{15, 12, 13, 14}};
   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction
endpackage

// File: rtl/salsa20_quarterround.sv
// salsa20_quarterround: combinational Salsa20 quarterround, each step feeding the next.
module salsa20_quarterround
   import salsa20_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);
   assign b_o = b_i ^ rotl32(a_i + d_i, ROT_B);
   assign c_o = c_i ^ rotl32(b_o + a_i, ROT_C);
   assign d_o = d_i ^ rotl32(c_o + b_o, ROT_D);
   assign a_o = a_i ^ rotl32(d_o + c_o, ROT_A);
endmodule

// File: rtl/salsa20_round_unit.sv
// salsa20_round_unit: column and row rounds of one 16-word state, optionally registered.
module salsa20_round_unit
   import salsa20_pkg::*;
#(
   parameter bit PIPELINE = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [511:0] data_in,
   output logic [511:0] odd_out,
   output logic [511:0] even_out
);
   logic [15:0][31:0] x, odd_d, even_d;
   assign x = data_in;
   for (genvar q = 0; q < 4; q++) begin : g_qr
      salsa20_quarterround u_col (
         .a_i(x[COL_IDX[q][0]]), .b_i(x[COL_IDX[q][1]]),
         .c_i(x[COL_IDX[q][2]]), .d_i(x[COL_IDX[q][3]]),
         .a_o(odd_d[COL_IDX[q][0]]), .b_o(odd_d[COL_IDX[q][1]]),
         .c_o(odd_d[COL_IDX[q][2]]), .d_o(odd_d[COL_IDX[q][3]])
      );
      salsa20_quarterround u_row (
         .a_i(x[ROW_IDX[q][0]]), .b_i(x[ROW_IDX[q][1]]),
         .c_i(x[ROW_IDX[q][2]]), .d_i(x[ROW_IDX[q][3]]),
         .a_o(even_d[ROW_IDX[q][0]]), .b_o(even_d[ROW_IDX[q][1]]),
         .c_o(even_d[ROW_IDX[q][2]]), .d_o(even_d[ROW_IDX[q][3]])
      );
   end
   if (PIPELINE) begin : g_pipe
      logic [511:0] odd_q, even_q;
      always_ff @(posedge clk) begin
         odd_q  <= reset ? '0 : odd_d;
         even_q <= reset ? '0 : even_d;
      end
      assign odd_out  = odd_q;
      assign even_out = even_q;
   end else begin : g_comb
      logic unused_clk_reset;
      assign unused_clk_reset = &{1'b0, clk, reset};
      assign odd_out  = odd_d;
      assign even_out = even_d;
   end
endmodule

// File: tb/tb_salsa20_round_unit.sv
// tb_salsa20_round_unit: vector table, random rounds, full Salsa20 hash and pipeline/reset sequences.
module tb_salsa20_round_unit;
   import salsa20_pkg::*;
   typedef logic [15:0][31:0] st_t;
   typedef struct {
      string name;
      st_t   din;
      st_t   odd;
      st_t   even;
   } vec_t;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [511:0] d0 = '0, d1 = '0;
   logic [511:0] odd0, even0, odd1, even1;
   int           checks = 0;
   int           errors = 0;
   vec_t         tv [4];
   salsa20_round_unit #(.PIPELINE(1'b0)) u0 (.clk(clk), .reset(reset), .data_in(d0), .odd_out(odd0), .even_out(even0));
   salsa20_round_unit #(.PIPELINE(1'b1)) u1 (.clk(clk), .reset(reset), .data_in(d1), .odd_out(odd1), .even_out(even1));
   always #5 clk = ~clk;
   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      logic [63:0] t;
      t = {v, v} << n;
      return t[63:32];
   endfunction
   function automatic st_t qr(input st_t s, input int a, input int b, input int c, input int d);
      s[b] = s[b] ^ rol(s[a] + s[d], 7);
      s[c] = s[c] ^ rol(s[b] + s[a], 9);
      s[d] = s[d] ^ rol(s[c] + s[b], 13);
      s[a] = s[a] ^ rol(s[d] + s[c], 18);
      return s;
   endfunction
   function automatic st_t m_col(input st_t s);
      int idx [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
      for (int k = 0; k < 16; k += 4) s = qr(s, idx[k], idx[k+1], idx[k+2], idx[k+3]);
      return s;
   endfunction
   function automatic st_t m_row(input st_t s);
      int idx [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
      for (int k = 0; k < 16; k += 4) s = qr(s, idx[k], idx[k+1], idx[k+2], idx[k+3]);
      return s;
   endfunction
   function automatic st_t m_hash(input st_t in);
      st_t s = in;
      for (int r = 0; r < 10; r++) s = m_row(m_col(s));
      for (int i = 0; i < 16; i++) s[i] = s[i] + in[i];
      return s;
   endfunction
   function automatic st_t rand_st();
      st_t s;
      for (int i = 0; i < 16; i++) s[i] = $urandom;
      return s;
   endfunction
   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   initial begin
      st_t s, a, b, key_st;
      tv[0] = '{"zero", '0, '0, '0};
      tv[1].name = "col_ones";
      tv[1].din  = '0;
      tv[1].din[0] = 1; tv[1].din[4] = 1; tv[1].din[8] = 1; tv[1].din[12] = 1;
      tv[1].odd  = '0;
      tv[1].odd[0] = 32'h10090288; tv[1].odd[4] = 32'h00000101;
      tv[1].odd[8] = 32'h00020401; tv[1].odd[12] = 32'h40a04001;
      tv[1].even = {32'h88000100, 32'h00402000, 32'h00000200, 32'h00000001,
                    32'h00000000, 32'h80040000, 32'h00002000, 32'h00000001,
                    32'h00010000, 32'h00000080, 32'h00048044, 32'h20100001,
                    32'h20500000, 32'h00010200, 32'h00000080, 32'h08008145};
      tv[2].name = "x0_one";
      tv[2].din  = '0;
      tv[2].din[0] = 1;
      tv[2].odd  = '0;
      tv[2].odd[0] = 32'h08008145; tv[2].odd[4] = 32'h00000080;
      tv[2].odd[8] = 32'h00010200; tv[2].odd[12] = 32'h20500000;
      tv[2].even = '0;
      tv[2].even[0] = 32'h08008145; tv[2].even[1] = 32'h00000080;
      tv[2].even[2] = 32'h00010200; tv[2].even[3] = 32'h20500000;
      tv[3].name = "all_ones";
      tv[3].din  = '1;
      tv[3].odd  = m_col('1);
      tv[3].even = m_row('1);
      for (int i = 0; i < 4; i++) begin
         d0 = tv[i].din;
         #1;
         chk({tv[i].name, "_odd"}, odd0, tv[i].odd);
         chk({tv[i].name, "_even"}, even0, tv[i].even);
      end
      for (int i = 0; i < 20; i++) begin
         s = rand_st();
         d0 = s;
         #1;
         chk("rand_odd", odd0, m_col(s));
         chk("rand_even", even0, m_row(s));
      end
      for (int n = 0; n < 3; n++) begin
         key_st = rand_st();
         for (int i = 0; i < 4; i++) key_st[5*i] = SIGMA[i];
         s = key_st;
         for (int r = 0; r < 20; r++) begin
            d0 = s;
            #1;
            s = (r % 2 == 0) ? st_t'(odd0) : st_t'(even0);
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] + key_st[i];
         chk("hash20", s, m_hash(key_st));
      end
      @(negedge clk);
      reset = 1'b1;
      d1 = rand_st();
      @(posedge clk); #1;
      chk("p1_reset_odd", odd1, '0);
      chk("p1_reset_even", even1, '0);
      reset = 1'b0;
      a = rand_st();
      d1 = a;
      #1;
      chk("p1_prelatch", odd1, '0);
      @(posedge clk); #1;
      chk("p1_lat_odd", odd1, m_col(a));
      chk("p1_lat_even", even1, m_row(a));
      b = rand_st();
      d1 = b;
      #1;
      chk("p1_hold", even1, m_row(a));
      @(posedge clk); #1;
      chk("p1_next_odd", odd1, m_col(b));
      chk("p1_next_even", even1, m_row(b));
      d1 = rand_st();
      reset = 1'b1;
      @(posedge clk); #1;
      chk("p1_midrst_odd", odd1, '0);
      chk("p1_midrst_even", even1, '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
